// File: rtl/des_iter_ctrl_if.sv
// Host/datapath control bundle for the iterative DES sequencer.
// The master side drives req; the slave (sequencer) drives everything else.
interface des_iter_ctrl_if #(
  parameter int W_RND = 5
);
  logic             req;
  logic             ack;
  logic             ld;
  logic             en;
  logic [W_RND-1:0] rnd;
  logic             sh2;
  logic             busy;

  modport master (
    output req,
    input  ack, ld, en, rnd, sh2, busy
  );

  modport slave (
    input  req,
    output ack, ld, en, rnd, sh2, busy
  );
endinterface

// File: rtl/des_iter_ctrl.sv
// Sequencer for the iterative DES datapath: one load strobe, then N_R round enables.
// Four-phase req/ack host handshake; all outputs are a Moore decode of registered state.
module des_iter_ctrl #(
  parameter int N_R   = 16,
  parameter int W_RND = 5
) (
  input  logic          clk,
  input  logic          rst,
  des_iter_ctrl_if.slave io
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [W_RND-1:0] RND_LAST = W_RND'(N_R - 1);

  state_e           state_q, state_d;
  logic [W_RND-1:0] rnd_q, rnd_d;

  logic             ack_o, ld_o, en_o, sh2_o, busy_o;
  logic [W_RND-1:0] rnd_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
    end
  end

  // rnd only advances inside RUN; every other path returns it to zero.
  always_comb begin
    state_d = state_q;
    rnd_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (io.req) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = io.req ? S_RUN : S_IDLE;
      end
      S_RUN: begin
        if (!io.req) begin
          state_d = S_IDLE;
        end else if (rnd_q == RND_LAST) begin
          state_d = S_DONE;
        end else begin
          rnd_d = rnd_q + W_RND'(1);
        end
      end
      S_DONE: begin
        if (!io.req) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    ack_o  = 1'b0;
    ld_o   = 1'b0;
    en_o   = 1'b0;
    sh2_o  = 1'b0;
    busy_o = 1'b0;
    rnd_o  = '0;
    case (state_q)
      S_LOAD: begin
        ld_o   = 1'b1;
        busy_o = 1'b1;
      end
      S_RUN: begin
        en_o   = 1'b1;
        busy_o = 1'b1;
        rnd_o  = rnd_q;
        // DES key schedule rotates by one in rounds 1, 2, 9 and 16.
        sh2_o  = !((rnd_q == W_RND'(0)) || (rnd_q == W_RND'(1)) ||
                   (rnd_q == W_RND'(8)) || (rnd_q == W_RND'(15)));
      end
      S_DONE: begin
        ack_o = 1'b1;
      end
      default: begin
        ack_o = 1'b0;
      end
    endcase
  end

  assign io.ack  = ack_o;
  assign io.ld   = ld_o;
  assign io.en   = en_o;
  assign io.sh2  = sh2_o;
  assign io.busy = busy_o;
  assign io.rnd  = rnd_o;

endmodule

// File: tb/tb_des_iter_ctrl.sv
// Directed bench for des_iter_ctrl: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them.
module tb_des_iter_ctrl;

  localparam int N_R   = 16;
  localparam int W_RND = 5;

  typedef struct packed {
    logic             ack;
    logic             ld;
    logic             en;
    logic             sh2;
    logic             busy;
    logic [W_RND-1:0] rnd;
  } outv_t;

  typedef struct {
    outv_t v;
    string tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  des_iter_ctrl_if #(.W_RND(W_RND)) bus ();

  des_iter_ctrl #(.N_R(N_R), .W_RND(W_RND)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] sh2_tab  = 16'h7EFC;  // bit i = sh2 in round i: 0,0,1,1,1,1,1,1,0,1,1,1,1,1,1,0

  function automatic outv_t o_idle();
    outv_t v;
    v = '0;
    return v;
  endfunction

  function automatic outv_t o_load();
    outv_t v;
    v      = '0;
    v.ld   = 1'b1;
    v.busy = 1'b1;
    return v;
  endfunction

  function automatic outv_t o_run(input int i);
    outv_t v;
    v      = '0;
    v.en   = 1'b1;
    v.busy = 1'b1;
    v.rnd  = W_RND'(i);
    v.sh2  = sh2_tab[i];
    return v;
  endfunction

  function automatic outv_t o_done();
    outv_t v;
    v     = '0;
    v.ack = 1'b1;
    return v;
  endfunction

  // Drive inputs for the next posedge and queue the outputs expected after it.
  task automatic step(input logic r, input logic q, input outv_t v, input string tag);
    exp_t item;
    @(negedge clk);
    #1;
    rst     = r;
    bus.req = q;
    item.v   = v;
    item.tag = tag;
    sb.push_back(item);
  endtask

  task automatic run_body(input int last, input string tag);
    for (int i = 0; i <= last; i++) step(1'b0, 1'b1, o_run(i), tag);
  endtask

  task automatic full_op(input int n_done, input string tag);
    step(1'b0, 1'b1, o_load(), tag);
    run_body(N_R - 1, tag);
    for (int i = 0; i < n_done; i++) step(1'b0, 1'b1, o_done(), tag);
  endtask

  task automatic idles(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, o_idle(), tag);
  endtask

  always @(negedge clk) begin
    exp_t  e;
    outv_t a;
    if (sb.size() > 0) begin
      e      = sb.pop_front();
      a.ack  = bus.ack;
      a.ld   = bus.ld;
      a.en   = bus.en;
      a.sh2  = bus.sh2;
      a.busy = bus.busy;
      a.rnd  = bus.rnd;
      n_checks++;
      if (a !== e.v) begin
        n_errors++;
        $display("FAIL %s: got ack=%b ld=%b en=%b sh2=%b busy=%b rnd=%0d, want ack=%b ld=%b en=%b sh2=%b busy=%b rnd=%0d",
                 e.tag, a.ack, a.ld, a.en, a.sh2, a.busy, a.rnd,
                 e.v.ack, e.v.ld, e.v.en, e.v.sh2, e.v.busy, e.v.rnd);
      end
      n_checks++;
      if ((a.ld && a.en) || (a.ack && (a.ld || a.en)) || (a.rnd > W_RND'(N_R - 1))) begin
        n_errors++;
        $display("FAIL invariant(%s): got ld=%b en=%b ack=%b rnd=%0d, want exclusive ld/en/ack and rnd<%0d",
                 e.tag, a.ld, a.en, a.ack, a.rnd, N_R);
      end
    end
  end

  initial begin
    bus.req = 1'b0;
    rst     = 1'b1;

    step(1'b1, 1'b0, o_idle(), "reset");
    step(1'b1, 1'b0, o_idle(), "reset");

    full_op(4, "op1");
    step(1'b0, 1'b0, o_idle(), "release");
    step(1'b0, 1'b0, o_idle(), "gap");

    // Second run with identical timing, then req held through DONE.
    full_op(50, "op2_hold");
    idles(2, "release2");

    step(1'b0, 1'b1, o_load(), "abort_run");
    run_body(7, "abort_run");
    step(1'b0, 1'b0, o_idle(), "abort_run_drop");
    idles(30, "abort_run_quiet");

    step(1'b0, 1'b1, o_load(), "rst_mid");
    run_body(10, "rst_mid");
    step(1'b1, 1'b1, o_idle(), "rst_mid_hit");
    full_op(2, "after_rst");
    idles(2, "after_rst_rel");

    step(1'b0, 1'b1, o_load(), "abort_last");
    run_body(N_R - 1, "abort_last");
    step(1'b0, 1'b0, o_idle(), "abort_last_drop");
    idles(5, "abort_last_quiet");

    step(1'b0, 1'b1, o_load(), "abort_load");
    step(1'b0, 1'b0, o_idle(), "abort_load_drop");
    idles(10, "abort_load_quiet");

    step(1'b1, 1'b1, o_idle(), "rst_req");
    idles(1, "rst_req_rel");

    full_op(2, "rst_done");
    step(1'b1, 1'b1, o_idle(), "rst_done_hit");
    step(1'b0, 1'b1, o_load(), "rst_done_reload");
    idles(3, "rst_done_rel");

    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/des_iter_ctrl.md
Name: des_iter_ctrl

Overview:
- Control sequencer for the iterative DES encryption datapath: pre-processing, one shared round plus key-schedule step, and post-processing.
- Accepts a req/ack four-phase handshake from the host.
- Issues a one-cycle load strobe, then N_R round-enable cycles with a round index and key-shift select.
- Holds ack until the host withdraws req.
- Sits beside the datapath registers and owns all of its enables. The datapath holds no control state of its own.

Parameters:
- N_R, 16: number of cipher rounds (matches `N_R`).
- W_RND, 5: width of the round index output. Must satisfy 2^W_RND > N_R.

Ports:
- clk  in  1: clock. All state updates on the posedge.
- rst  in  1: synchronous, active-high reset.
- req  in  1: host request, level-sensitive. k and m are stable while req=1.
- ack  out 1: result valid. c is stable while ack=1.
- ld   out 1: load strobe. The datapath captures the pre_processing outputs (L0, R0, CD0) on this cycle.
- en   out 1: round enable. The datapath captures the round and key_schedule outputs on this cycle.
- rnd  out W_RND: current round index, driven to key_schedule i.
- sh2  out 1: key rotate amount for the current round. 0 = rotate by 1, 1 = rotate by 2.
- busy out 1: 1 in LOAD or RUN.

Behaviour:
- States: IDLE, LOAD, RUN, DONE. Binary encoding.
- Outputs are a Moore decode of the state register and the rnd counter. There is no combinational path from req to any output.
- Reset: rst=1 at a posedge forces the following, regardless of current state, including mid-RUN or DONE:
  - state=IDLE, rnd=0
  - ld=0, en=0, ack=0, sh2=0, busy=0
  - rst has priority over every other condition.
- IDLE:
  - All outputs 0, rnd=0.
  - req=1 sampled goes to LOAD. Otherwise stay.
- LOAD:
  - ld=1, busy=1, en=0, rnd=0.
  - Lasts exactly one cycle.
  - Next state is RUN if req=1, otherwise IDLE (abort).
- RUN:
  - en=1, busy=1.
  - rnd counts 0..N_R-1, incrementing by 1 per cycle.
  - sh2 = 0 when rnd ∈ {0, 1, 8, 15}, else 1.
  - When rnd==N_R-1, next state is DONE and rnd clears to 0.
  - req=0 sampled in any RUN cycle goes to IDLE next cycle with rnd=0. ack is never raised for an aborted operation. Datapath contents after an abort are don't-care.
- DONE:
  - ack=1, en=0, ld=0, busy=0, rnd=0.
  - Stay while req=1.
  - req=0 sampled goes to IDLE, so ack falls one cycle after req falls.
- Latency: let edge T be the first posedge sampling req=1 in IDLE.
  - ld=1 during cycle T+1.
  - en=1 during cycles T+2..T+N_R+1, with rnd = 0..N_R-1.
  - ack=1 from cycle T+N_R+2. That is 18 cycles for N_R=16.
- Back-to-back:
  - A new operation starts only after ack has fallen, i.e. after passing through IDLE with req sampled 0 at least once.
  - req held at 1 through DONE does not retrigger.
- Simultaneous events:
  - rst together with req: reset wins.
  - req falling on the same edge rnd reaches N_R-1: abort wins, next state IDLE, ack stays 0.
- Invariants:
  - ld and en are never 1 in the same cycle.
  - ack=1 implies en=0 and ld=0.
  - Exactly N_R en cycles occur per completed operation.
  - rnd never exceeds N_R-1.
- Unreachable encodings: go to IDLE on the next edge with all outputs 0.

Test Plan:
- Reset then single operation: rst=1 for 2 cycles, then req=1 held. Required:
  - ld=1 for exactly 1 cycle.
  - en=1 for 16 consecutive cycles with rnd 0..15.
  - sh2 pattern 0,0,1,1,1,1,1,1,0,1,1,1,1,1,1,0.
  - ack=1 at cycle T+18 and held.
  - With the datapath attached, k=0x133457799BBCDFF1, m=0x0123456789ABCDEF gives c=0x85E813540F0AB405.
- Handshake release: after ack=1, drop req. Required: ack=0 one cycle later, state IDLE. req re-raised 2 cycles later gives a second complete run with identical timing.
- Abort in RUN: drop req when rnd=7. Required: next cycle en=0, rnd=0, busy=0. ack stays 0 for the following 30 cycles with req=0.
- Reset mid-operation: assert rst when rnd=10, with req still 1. Required: next cycle all outputs 0. With rst released and req held at 1, a fresh LOAD begins on the following cycle.
- Held req no retrigger: keep req=1 for 50 cycles after ack. Required: ack stays 1, ld and en stay 0, rnd=0 throughout.
- Abort in LOAD: req high for exactly 1 sampled edge. Required: ld pulses once, no en cycles, ack stays 0.
